period_meter: RTL

Measures the period and high time of a slow, asynchronous square wave in `clk` cycles. It is the measuring end of the board's clock-division path: it reads back the divided clocks produced in the fabric, such as the 1 Hz tick from 125 MHz, or external slow signals. Results go to display and check logic through a valid strobe. It supports single-shot and continuous measurement, with a timeout for stuck inputs.

---
 rtl/period_meter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/period_meter.sv
// rtl/period_meter.sv - measures period and high time of a slow asynchronous input in clk cycles
module period_meter #(
    parameter int          CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 250_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             start,
    input  logic             cont,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             busy,
    output logic             timeout
);
    typedef enum logic [2:0] {S_IDLE, S_ARM, S_HIGH, S_LOW, S_DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    state_t           state_nxt;
    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             rise;
    logic             fall;
    logic             measuring;
    logic             tmo_hit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] tmo;
    logic [CNT_W-1:0] hi_cap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise      = sync2 & ~prev;
    assign fall      = ~sync2 & prev;
    assign measuring = (state == S_ARM) || (state == S_HIGH) || (state == S_LOW);
    assign tmo_hit   = measuring && (tmo == TMO_LAST);
    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Timeout outranks any edge seen in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_ARM;
            S_ARM: begin
                if (tmo_hit)   state_nxt = S_IDLE;
                else if (rise) state_nxt = S_HIGH;
            end
            S_HIGH: begin
                if (tmo_hit)   state_nxt = S_IDLE;
                else if (fall) state_nxt = S_LOW;
            end
            S_LOW: begin
                if (tmo_hit)   state_nxt = S_IDLE;
                else if (rise) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = cont ? S_HIGH : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != S_IDLE);
        valid = (state == S_DONE);
    end

    // The closing rise restarts cnt so a continuous run stays aligned with the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            tmo       <= '0;
            hi_cap    <= '0;
            period    <= '0;
            high_time <= '0;
            timeout   <= 1'b0;
        end else begin
            timeout <= tmo_hit;
            case (state)
                S_ARM, S_HIGH, S_LOW: begin
                    tmo <= tmo + CNT_ONE;
                    cnt <= cnt_inc;
                    if (!tmo_hit) begin
                        if (state == S_ARM && rise) begin
                            cnt <= '0;
                        end
                        if (state == S_HIGH && fall) begin
                            hi_cap <= cnt_inc;
                        end
                        if (state == S_LOW && rise) begin
                            period    <= cnt_inc;
                            high_time <= hi_cap;
                            cnt       <= '0;
                        end
                    end
                end
                S_DONE: begin
                    tmo <= '0;
                    cnt <= cnt_inc;
                end
                default: begin
                    tmo <= '0;
                    cnt <= '0;
                end
            endcase
        end
    end
endmodule
